hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It is the producer of the ID/EX bubble (`IR_E_clr`) and of the PC and IF/ID hold enables. It decodes the instructions held in D, E and M and freezes D while injecting a nop into E when a hazard cannot be forwarded: load-use, branch/jump compare in D, or a multi-cycle multiply/divide still busy. It also owns the HI/LO busy timer and a saturating stall-cycle performance counter.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after mult/multu leaves E.
- `DIV_CYCLES`, default 10: busy cycles after div/divu leaves E.
- `WIDTH`, default 32: instruction and counter width.

Ports:
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: synchronous, active-high.
- `IR_D  in  WIDTH`: instruction in decode.
- `IR_E  in  WIDTH`: instruction in execute (ID/EX output).
- `IR_M  in  WIDTH`: instruction in memory stage.
- `PC_en  out  1`: 1 means PC updates.
- `IF_ID_en  out  1`: 1 means the IF/ID register loads.
- `IR_E_clr  out  1`: 1 means ID/EX loads a nop.
- `md_busy  out  1`: HI/LO unit busy; the MDU holds its result.
- `stall_cnt  out  WIDTH`: number of stalled cycles since reset, saturating.

## Operation
Field helpers: rs = IR[25:21], rt = IR[20:16], rd = IR[15:11].

Destination register of an instruction:
- R-type ALU and jalr: rd.
- I-type ALU and loads: rt.
- jal: 31.
- Anything else: none.
- A destination of 0 counts as none.

Sources of the instruction in D:
- rs: read by all except j, jal, lui, mfhi, mflo, sll, srl, sra.
- rt: read by R-type, stores, beq, bne.

Stall terms:
- **lu**: IR_E is a load (lw, lh, lhu, lb, lbu) and its dest matches a D source.
- **br**: D is beq, bne, jr or jalr, and either:
  - the dest of IR_E matches a D source, or
  - IR_M is a load whose dest matches a D source.
- **md**: D is mult, multu, div, divu, mfhi, mflo, mthi or mtlo, and either:
  - `md_busy` = 1, or
  - IR_E is mult, multu, div or divu.

Outputs:
- stall = lu | br | md.
- `PC_en` = `IF_ID_en` = ~stall.
- `IR_E_clr` = stall.
- All of these are combinational from the current inputs and state.

Busy timer (registered counter `md_cnt`):
- IR_E is mult or multu: load `MULT_CYCLES`.
- IR_E is div or divu: load `DIV_CYCLES`.
- Otherwise, if nonzero: decrement.
- `md_busy` = (`md_cnt` != 0).
- A load while nonzero reloads the counter. This overrides the decrement.

Stall counter:
- Increments by 1 on each cycle where stall = 1.
- Holds at all-ones.

Reset:
- `md_cnt` = 0 and `stall_cnt` = 0 on the first edge with reset high.
- Hence `md_busy` = 0 after reset.
- Combinational outputs follow their inputs. With IR_D/E/M = 0 (nop): `PC_en` = 1, `IF_ID_en` = 1, `IR_E_clr` = 0.
- Reset in mid-busy clears the busy state immediately at that edge.

## Timing
- Stall outputs have zero-cycle latency: valid in the same cycle as IR_D/IR_E/IR_M.
- The bubble enters E at the next edge. IR_D is held at that edge.
- Mult in E during cycle t:
  - `md_busy` = 1 for cycles t+1 .. t+MULT_CYCLES.
  - `md_busy` = 0 at cycle t+MULT_CYCLES+1.
  - An md-class instruction in D stalls in cycles t .. t+MULT_CYCLES.
- Load-use costs exactly 1 stall cycle.
- Branch after an ALU producer costs 1 stall cycle.
- Branch after a load costs 2 stall cycles: one for the E match, one for the M match.
- Reset has priority over a counter load on the same edge.
- `stall_cnt` wrap is forbidden; it saturates at 0xFFFFFFFF.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct constants;
  - the instruction-class decode functions (is_load, is_branch_d, is_md, is_md_start, dest_reg, reads_rs, reads_rt), reused by the forwarding unit.
- One sub-module, `md_busy_timer`:
  - parameterised load values;
  - inputs start_mult, start_div, reset;
  - output busy.
- Everything else is flat combinational logic plus the stall counter.

## Test plan
1. Load-use: IR_E = `lw $8,0($9)`, IR_D = `add $10,$8,$1`. Required: `IR_E_clr` = 1, `PC_en` = 0, `IF_ID_en` = 0 for 1 cycle, then 0/1/1; `stall_cnt` +1.
2. Branch after load: `lw $8` followed by `beq $8,$0`. Required: stall in 2 consecutive cycles (E match, then M match); `stall_cnt` = 2.
3. Mult then mflo: `mult` in E at cycle t, `mflo` in D. Required: stall in cycles t..t+5, `md_busy` high in t+1..t+5, released at t+6.
4. Div timer: with `DIV_CYCLES` = 10, a `div` in E gives `md_busy` high for exactly 10 cycles. An unrelated `add` in D during this time is not stalled.
5. Reset mid-busy: reset at t+2 after a `div`. Required: `md_busy` = 0 and `stall_cnt` = 0 at t+3; `mflo` in D proceeds with no stall.
6. Register $0 and no-hazard cases: `lw $0` then `add $1,$0,$0` gives no stall. Independent instructions give `PC_en` = 1 and `IR_E_clr` = 0 every cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Opcode/funct constants and instruction-class decode helpers shared by the
// hazard controller and the forwarding unit.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    function automatic logic [5:0] op_of(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [5:0] fn_of(input logic [31:0] ir);
        return ir[5:0];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic is_rtype(input logic [31:0] ir);
        return op_of(ir) == OP_RTYPE;
    endfunction

    function automatic logic is_load(input logic [31:0] ir);
        logic [5:0] op;
        op = op_of(ir);
        return op == OP_LW || op == OP_LH || op == OP_LHU ||
               op == OP_LB || op == OP_LBU;
    endfunction

    function automatic logic is_store(input logic [31:0] ir);
        logic [5:0] op;
        op = op_of(ir);
        return op == OP_SW || op == OP_SH || op == OP_SB;
    endfunction

    function automatic logic is_branch_d(input logic [31:0] ir);
        logic [5:0] op;
        logic [5:0] fn;
        op = op_of(ir);
        fn = fn_of(ir);
        return op == OP_BEQ || op == OP_BNE ||
               (op == OP_RTYPE && (fn == FN_JR || fn == FN_JALR));
    endfunction

    function automatic logic is_mult_start(input logic [31:0] ir);
        return is_rtype(ir) &&
               (fn_of(ir) == FN_MULT || fn_of(ir) == FN_MULTU);
    endfunction

    function automatic logic is_div_start(input logic [31:0] ir);
        return is_rtype(ir) &&
               (fn_of(ir) == FN_DIV || fn_of(ir) == FN_DIVU);
    endfunction

    function automatic logic is_md_start(input logic [31:0] ir);
        return is_mult_start(ir) || is_div_start(ir);
    endfunction

    function automatic logic is_md(input logic [31:0] ir);
        logic [5:0] fn;
        fn = fn_of(ir);
        return is_md_start(ir) ||
               (is_rtype(ir) && (fn == FN_MFHI || fn == FN_MFLO ||
                                 fn == FN_MTHI || fn == FN_MTLO));
    endfunction

    function automatic logic is_r_alu(input logic [31:0] ir);
        logic [5:0] fn;
        fn = fn_of(ir);
        return is_rtype(ir) &&
               (fn == FN_SLL  || fn == FN_SRL  || fn == FN_SRA  ||
                fn == FN_SLLV || fn == FN_SRLV || fn == FN_SRAV ||
                fn == FN_ADD  || fn == FN_ADDU || fn == FN_SUB  ||
                fn == FN_SUBU || fn == FN_AND  || fn == FN_OR   ||
                fn == FN_XOR  || fn == FN_NOR  || fn == FN_SLT  ||
                fn == FN_SLTU || fn == FN_MFHI || fn == FN_MFLO);
    endfunction

    function automatic logic is_i_alu(input logic [31:0] ir);
        logic [5:0] op;
        op = op_of(ir);
        return op == OP_ADDI || op == OP_ADDIU || op == OP_SLTI ||
               op == OP_SLTIU || op == OP_ANDI || op == OP_ORI ||
               op == OP_XORI || op == OP_LUI;
    endfunction

    // Returns 0 when the instruction writes no register ($0 is never a dest).
    function automatic logic [4:0] dest_reg(input logic [31:0] ir);
        logic [4:0] d;
        d = 5'd0;
        if (is_r_alu(ir) ||
            (is_rtype(ir) && fn_of(ir) == FN_JALR))
            d = rd_of(ir);
        else if (is_i_alu(ir) || is_load(ir))
            d = rt_of(ir);
        else if (op_of(ir) == OP_JAL)
            d = 5'd31;
        return d;
    endfunction

    function automatic logic reads_rs(input logic [31:0] ir);
        logic [5:0] op;
        logic [5:0] fn;
        op = op_of(ir);
        fn = fn_of(ir);
        if (op == OP_J || op == OP_JAL || op == OP_LUI)
            return 1'b0;
        if (op == OP_RTYPE &&
            (fn == FN_MFHI || fn == FN_MFLO || fn == FN_SLL ||
             fn == FN_SRL  || fn == FN_SRA))
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic reads_rt(input logic [31:0] ir);
        return is_rtype(ir) || is_store(ir) ||
               op_of(ir) == OP_BEQ || op_of(ir) == OP_BNE;
    endfunction

    function automatic logic src_hit(input logic [31:0] ir_d,
                                     input logic [4:0]  dst);
        return dst != 5'd0 &&
               ((reads_rs(ir_d) && rs_of(ir_d) == dst) ||
                (reads_rt(ir_d) && rt_of(ir_d) == dst));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage instructions in, hold/flush
// controls and status out.
interface hazard_stall_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] IR_D;
    logic [WIDTH-1:0] IR_E;
    logic [WIDTH-1:0] IR_M;
    logic             PC_en;
    logic             IF_ID_en;
    logic             IR_E_clr;
    logic             md_busy;
    logic [WIDTH-1:0] stall_cnt;

    modport master (
        output IR_D, IR_E, IR_M,
        input  PC_en, IF_ID_en, IR_E_clr, md_busy, stall_cnt
    );

    modport slave (
        input  IR_D, IR_E, IR_M,
        output PC_en, IF_ID_en, IR_E_clr, md_busy, stall_cnt
    );
endinterface

// File: rtl/md_busy_timer.sv
// HI/LO busy timer: loaded when a mult/div leaves E, counts down to idle.
module md_busy_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    output logic busy
);
    localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ?
                          DIV_CYCLES : MULT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    logic [CW-1:0] md_cnt;

    // A new start reloads even while busy; reset beats any load.
    always_ff @(posedge clk) begin
        if (reset)
            md_cnt <= '0;
        else if (start_mult)
            md_cnt <= CW'(MULT_CYCLES);
        else if (start_div)
            md_cnt <= CW'(DIV_CYCLES);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

    assign busy = (md_cnt != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller: detects non-forwardable hazards, freezes PC and IF/ID,
// injects an ID/EX bubble, and counts stalled cycles.
module hazard_stall_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int WIDTH       = 32
) (
    input logic                clk,
    input logic                reset,
    hazard_stall_ctrl_if.slave bus
);
    logic [31:0] ir_d;
    logic [31:0] ir_e;
    logic [31:0] ir_m;
    logic [4:0]  dst_e;
    logic [4:0]  dst_m;
    logic        lu;
    logic        br;
    logic        md;
    logic        stall;
    logic        busy;
    logic [WIDTH-1:0] cnt;

    assign ir_d = bus.IR_D[31:0];
    assign ir_e = bus.IR_E[31:0];
    assign ir_m = bus.IR_M[31:0];

    assign dst_e = dest_reg(ir_e);
    assign dst_m = dest_reg(ir_m);

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .start_mult (is_mult_start(ir_e)),
        .start_div  (is_div_start(ir_e)),
        .busy       (busy)
    );

    always_comb begin
        lu = is_load(ir_e) && src_hit(ir_d, dst_e);
        // Branch operands are compared in D, so even ALU results in E
        // and load data still in M are too late to forward.
        br = is_branch_d(ir_d) &&
             (src_hit(ir_d, dst_e) ||
              (is_load(ir_m) && src_hit(ir_d, dst_m)));
        md = is_md(ir_d) && (busy || is_md_start(ir_e));
        stall = lu | br | md;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (stall && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign bus.PC_en     = ~stall;
    assign bus.IF_ID_en  = ~stall;
    assign bus.IR_E_clr  = stall;
    assign bus.md_busy   = busy;
    assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for the hazard controller.
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    hazard_stall_ctrl_if #(.WIDTH(32)) bus ();

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .WIDTH       (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag,
                             input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt,
                                          input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs,
                                          input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'h0000};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [31:0] d, input logic [31:0] e,
                          input logic [31:0] m);
        bus.IR_D = d;
        bus.IR_E = e;
        bus.IR_M = m;
        #1;
    endtask

    task automatic check_stall(input string tag, input logic s);
        expect_eq({tag, ".clr"},  32'(bus.IR_E_clr), 32'(s));
        expect_eq({tag, ".pc"},   32'(bus.PC_en),    32'(!s));
        expect_eq({tag, ".ifid"}, 32'(bus.IF_ID_en), 32'(!s));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_ir(32'h0, 32'h0, 32'h0);
        next_cycle();
        reset = 1'b0;
    endtask

    logic [31:0] lw8, add10, beq8, mult23, mflo4, div23, add5, lw0, add1;
    logic [31:0] d_vec [6];
    logic [31:0] e_vec [6];
    logic [31:0] m_vec [6];
    logic        s_vec [6];

    initial begin
        lw8    = i_ins(6'h23, 9, 8);
        add10  = r_ins(8, 1, 10, 6'h20);
        beq8   = i_ins(6'h04, 8, 0);
        mult23 = r_ins(2, 3, 0, 6'h18);
        mflo4  = r_ins(0, 0, 4, 6'h12);
        div23  = r_ins(2, 3, 0, 6'h1a);
        add5   = r_ins(6, 7, 5, 6'h20);
        lw0    = i_ins(6'h23, 1, 0);
        add1   = r_ins(0, 0, 1, 6'h20);

        // reset state
        do_reset();
        expect_eq("rst.busy", 32'(bus.md_busy), 32'd0);
        expect_eq("rst.cnt",  bus.stall_cnt,    32'd0);
        check_stall("rst", 1'b0);

        // load-use: one bubble
        set_ir(add10, lw8, 32'h0);
        check_stall("lu0", 1'b1);
        next_cycle();
        set_ir(add10, 32'h0, lw8);
        check_stall("lu1", 1'b0);
        expect_eq("lu.cnt", bus.stall_cnt, 32'd1);

        // branch after load: E match then M match
        do_reset();
        set_ir(beq8, lw8, 32'h0);
        check_stall("bl0", 1'b1);
        next_cycle();
        set_ir(beq8, 32'h0, lw8);
        check_stall("bl1", 1'b1);
        next_cycle();
        set_ir(beq8, 32'h0, 32'h0);
        check_stall("bl2", 1'b0);
        expect_eq("bl.cnt", bus.stall_cnt, 32'd2);

        // mult then mflo: stall t..t+5, busy t+1..t+5
        do_reset();
        set_ir(mflo4, mult23, 32'h0);
        for (int k = 0; k <= 6; k++) begin
            if (k == 1) set_ir(mflo4, 32'h0, mult23);
            if (k == 2) set_ir(mflo4, 32'h0, 32'h0);
            expect_eq($sformatf("mul.clr%0d", k),
                      32'(bus.IR_E_clr), 32'(k <= 5));
            expect_eq($sformatf("mul.busy%0d", k),
                      32'(bus.md_busy), 32'(k >= 1 && k <= 5));
            if (k < 6) next_cycle();
        end
        expect_eq("mul.cnt", bus.stall_cnt, 32'd6);

        // div: busy exactly 10 cycles, unrelated add not stalled
        do_reset();
        set_ir(add5, div23, 32'h0);
        for (int k = 0; k <= 11; k++) begin
            if (k == 1) set_ir(add5, 32'h0, div23);
            if (k == 2) set_ir(add5, 32'h0, 32'h0);
            expect_eq($sformatf("div.busy%0d", k),
                      32'(bus.md_busy), 32'(k >= 1 && k <= 10));
            expect_eq($sformatf("div.clr%0d", k),
                      32'(bus.IR_E_clr), 32'd0);
            if (k < 11) next_cycle();
        end
        expect_eq("div.cnt", bus.stall_cnt, 32'd0);

        // reset in mid-busy
        do_reset();
        set_ir(mflo4, div23, 32'h0);
        next_cycle();
        set_ir(mflo4, 32'h0, div23);
        next_cycle();
        set_ir(mflo4, 32'h0, 32'h0);
        expect_eq("rb.busy2", 32'(bus.md_busy), 32'd1);
        expect_eq("rb.cnt2",  bus.stall_cnt,    32'd2);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        set_ir(mflo4, 32'h0, 32'h0);
        expect_eq("rb.busy3", 32'(bus.md_busy), 32'd0);
        expect_eq("rb.cnt3",  bus.stall_cnt,    32'd0);
        check_stall("rb3", 1'b0);

        // $0 and assorted vectors (addi $9 -> bne $9; jal -> jr $31)
        do_reset();
        d_vec[0] = add1;                  e_vec[0] = lw0;
        m_vec[0] = 32'h0;                 s_vec[0] = 1'b0;
        d_vec[1] = r_ins(3, 4, 5, 6'h20); e_vec[1] = r_ins(6, 7, 8, 6'h22);
        m_vec[1] = i_ins(6'h23, 1, 9);    s_vec[1] = 1'b0;
        d_vec[2] = i_ins(6'h05, 9, 0);    e_vec[2] = i_ins(6'h08, 1, 9);
        m_vec[2] = 32'h0;                 s_vec[2] = 1'b1;
        d_vec[3] = r_ins(31, 0, 0, 6'h08); e_vec[3] = {6'h03, 26'h10};
        m_vec[3] = 32'h0;                 s_vec[3] = 1'b1;
        d_vec[4] = add10;                 e_vec[4] = r_ins(1, 2, 8, 6'h20);
        m_vec[4] = 32'h0;                 s_vec[4] = 1'b0;
        d_vec[5] = {6'h02, 26'h40};       e_vec[5] = lw8;
        m_vec[5] = 32'h0;                 s_vec[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_ir(d_vec[i], e_vec[i], m_vec[i]);
            check_stall($sformatf("vec%0d", i), s_vec[i]);
            next_cycle();
        end
        expect_eq("vec.cnt", bus.stall_cnt, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
